// File: rtl/regfile_pkg.sv
// -----------------------------------------------------------------------------
// regfile_pkg
// Shared definitions for the register-file write-back scheduler slice.
//   ADDR_W / DATA_W : register address and data widths of the 32x32 file
//   IDX_W           : width of a requester index (up to 8 requesters)
//   ZERO_REG        : hard-wired zero register; writes to it are suppressed
//   reg_addr_t, reg_data_t, req_idx_t, wb_slot_t : common types
//   rr_next()       : round-robin successor of a requester index
// -----------------------------------------------------------------------------
package regfile_pkg;

   localparam int ADDR_W = 5;
   localparam int DATA_W = 32;
   localparam int IDX_W  = 3;

   localparam logic [ADDR_W-1:0] ZERO_REG = 5'd0;

   typedef logic [ADDR_W-1:0] reg_addr_t;
   typedef logic [DATA_W-1:0] reg_data_t;
   typedef logic [IDX_W-1:0]  req_idx_t;

   typedef struct packed {
      logic      vld;
      reg_addr_t addr;
      reg_data_t data;
   } wb_slot_t;

   // (idx + 1) mod n, for n in 2..8
   function automatic req_idx_t rr_next(input req_idx_t idx, input logic [3:0] n);
      logic [3:0] nxt_v;
      nxt_v = {1'b0, idx} + 4'd1;
      if (nxt_v >= n) begin
         rr_next = 3'd0;
      end else begin
         rr_next = nxt_v[IDX_W-1:0];
      end
   endfunction

endpackage

// File: rtl/rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational rotating-priority picker: returns the first eligible request
// at or after `start`, wrapping modulo N.
//   N      : number of requesters (2..8)
//   req    in  N      request vector
//   excl   in  N      exclusion mask (excluded requests are never picked)
//   start  in  IDX_W  index with highest priority this cycle (must be < N)
//   gnt    out N      one-hot grant (all zero when nothing is eligible)
//   idx    out IDX_W  index of the granted requester
//   found  out 1      a requester was granted
// -----------------------------------------------------------------------------
module rr_pick
   import regfile_pkg::*;
#(
   parameter int N = 3
) (
   input  logic [N-1:0]     req,
   input  logic [N-1:0]     excl,
   input  logic [IDX_W-1:0] start,
   output logic [N-1:0]     gnt,
   output logic [IDX_W-1:0] idx,
   output logic             found
);

   logic [N-1:0] elig_s;
   logic [3:0]   dist_s;
   logic [3:0]   best_s;

   assign elig_s = req & ~excl;

   // Pick the eligible requester with the smallest rotated distance from start
   always_comb begin
      found  = 1'b0;
      idx    = '0;
      best_s = 4'd0;
      dist_s = 4'd0;
      for (int i = 0; i < N; i++) begin
         if (4'(i) >= {1'b0, start}) begin
            dist_s = 4'(i) - {1'b0, start};
         end else begin
            dist_s = 4'(i) + 4'(N) - {1'b0, start};
         end
         if (elig_s[i] && (!found || (dist_s < best_s))) begin
            best_s = dist_s;
            idx    = IDX_W'(i);
            found  = 1'b1;
         end else begin
            best_s = best_s;
         end
      end
   end

   // Expand the winning index into a one-hot grant
   always_comb begin
      gnt = '0;
      for (int i = 0; i < N; i++) begin
         gnt[i] = found && (idx == IDX_W'(i));
      end
   end

endmodule

// File: rtl/regfile_wb_scheduler.sv
// -----------------------------------------------------------------------------
// regfile_wb_scheduler
// Round-robin write-back scheduler for a dual-write-port register file.
// Up to two requesters are granted per cycle; the second grant never targets
// the same register as the first, so same-register writes land in scan order.
// Granted writes are registered and drive the register file write ports for
// the following cycle (the file writes on the negedge).
//
// Optional feature macro: REGFILE_WB_BYPASS_EN (adds read-port forwarding of
// the registered writes so readers see them before the negedge write).
//
// Ports:
//   clk, rst               clock; asynchronous active-high reset
//   req_valid/req_ready    per-requester handshake (ready is combinational)
//   req_reg/req_data       packed per-requester destination and data
//   write_reg1/2, write_data1/2, reg_write1/2   registered write ports
//   read_reg1/2, rf_data1/2, read_data1/2       bypass ports (macro only)
// -----------------------------------------------------------------------------
module regfile_wb_scheduler #(
   parameter int NUM_REQ = 3,
   parameter int ADDR_W  = 5,
   parameter int DATA_W  = 32
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [NUM_REQ-1:0]          req_valid,
   output logic [NUM_REQ-1:0]          req_ready,
   input  logic [NUM_REQ*ADDR_W-1:0]   req_reg,
   input  logic [NUM_REQ*DATA_W-1:0]   req_data,
`ifdef REGFILE_WB_BYPASS_EN
   input  logic [ADDR_W-1:0]           read_reg1,
   input  logic [ADDR_W-1:0]           read_reg2,
   input  logic [DATA_W-1:0]           rf_data1,
   input  logic [DATA_W-1:0]           rf_data2,
   output logic [DATA_W-1:0]           read_data1,
   output logic [DATA_W-1:0]           read_data2,
`endif
   output logic [ADDR_W-1:0]           write_reg1,
   output logic [DATA_W-1:0]           write_data1,
   output logic                        reg_write1,
   output logic [ADDR_W-1:0]           write_reg2,
   output logic [DATA_W-1:0]           write_data2,
   output logic                        reg_write2
);

   import regfile_pkg::*;

   logic [IDX_W-1:0]   rr_ptr_r;
   logic [IDX_W-1:0]   rr_nxt_s;
   logic [NUM_REQ-1:0] valid_s;
   logic [NUM_REQ-1:0] gnt1_s;
   logic [NUM_REQ-1:0] gnt2_s;
   logic [NUM_REQ-1:0] excl2_s;
   logic [IDX_W-1:0]   idx1_s;
   logic [IDX_W-1:0]   idx2_s;
   logic               found1_s;
   logic               found2_s;
   logic [ADDR_W-1:0]  slot1_reg_s;
   logic [ADDR_W-1:0]  slot2_reg_s;
   logic [DATA_W-1:0]  slot1_data_s;
   logic [DATA_W-1:0]  slot2_data_s;

   // Nothing is granted while reset is asserted
   assign valid_s   = rst ? '0 : req_valid;
   assign req_ready = gnt1_s | gnt2_s;

   rr_pick #(.N(NUM_REQ)) u_pick1 (
      .req   (valid_s),
      .excl  ({NUM_REQ{1'b0}}),
      .start (rr_ptr_r),
      .gnt   (gnt1_s),
      .idx   (idx1_s),
      .found (found1_s)
   );

   // Slot 2 scans from the same pointer; slot 1 is the first valid requester,
   // so excluding it (and its register) yields the next distinct-reg requester.
   rr_pick #(.N(NUM_REQ)) u_pick2 (
      .req   (valid_s),
      .excl  (excl2_s),
      .start (rr_ptr_r),
      .gnt   (gnt2_s),
      .idx   (idx2_s),
      .found (found2_s)
   );

   // Select the slot-1 destination and data with the one-hot grant
   always_comb begin
      slot1_reg_s  = '0;
      slot1_data_s = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         slot1_reg_s  = slot1_reg_s  | ({ADDR_W{gnt1_s[i]}} & req_reg[i*ADDR_W +: ADDR_W]);
         slot1_data_s = slot1_data_s | ({DATA_W{gnt1_s[i]}} & req_data[i*DATA_W +: DATA_W]);
      end
   end

   // Exclude slot 1 and every requester targeting slot 1's register
   always_comb begin
      excl2_s = gnt1_s;
      for (int i = 0; i < NUM_REQ; i++) begin
         excl2_s[i] = gnt1_s[i] | (found1_s && (req_reg[i*ADDR_W +: ADDR_W] == slot1_reg_s));
      end
   end

   // Select the slot-2 destination and data with the one-hot grant
   always_comb begin
      slot2_reg_s  = '0;
      slot2_data_s = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         slot2_reg_s  = slot2_reg_s  | ({ADDR_W{gnt2_s[i]}} & req_reg[i*ADDR_W +: ADDR_W]);
         slot2_data_s = slot2_data_s | ({DATA_W{gnt2_s[i]}} & req_data[i*DATA_W +: DATA_W]);
      end
   end

   // Pointer moves past the last granted requester; holds with no grant
   always_comb begin
      if (found2_s) begin
         rr_nxt_s = rr_next(idx2_s, 4'(NUM_REQ));
      end else if (found1_s) begin
         rr_nxt_s = rr_next(idx1_s, 4'(NUM_REQ));
      end else begin
         rr_nxt_s = rr_ptr_r;
      end
   end

   // Arbitration pointer and registered write ports; r0 writes are dropped
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_ptr_r    <= '0;
         reg_write1  <= 1'b0;
         reg_write2  <= 1'b0;
         write_reg1  <= '0;
         write_reg2  <= '0;
         write_data1 <= '0;
         write_data2 <= '0;
      end else begin
         rr_ptr_r   <= rr_nxt_s;
         reg_write1 <= found1_s && (slot1_reg_s != ADDR_W'(ZERO_REG));
         reg_write2 <= found2_s && (slot2_reg_s != ADDR_W'(ZERO_REG));
         if (found1_s) begin
            write_reg1  <= slot1_reg_s;
            write_data1 <= slot1_data_s;
         end
         if (found2_s) begin
            write_reg2  <= slot2_reg_s;
            write_data2 <= slot2_data_s;
         end
      end
   end

`ifdef REGFILE_WB_BYPASS_EN
   // Forward the pending writes; reg_writeN is never set for r0, and the
   // explicit r0 check keeps r0 reads on the raw file data regardless.
   always_comb begin
      if ((read_reg1 != ADDR_W'(ZERO_REG)) && reg_write2 && (write_reg2 == read_reg1)) begin
         read_data1 = write_data2;
      end else if ((read_reg1 != ADDR_W'(ZERO_REG)) && reg_write1 && (write_reg1 == read_reg1)) begin
         read_data1 = write_data1;
      end else begin
         read_data1 = rf_data1;
      end
   end

   // Same forwarding for read port 2
   always_comb begin
      if ((read_reg2 != ADDR_W'(ZERO_REG)) && reg_write2 && (write_reg2 == read_reg2)) begin
         read_data2 = write_data2;
      end else if ((read_reg2 != ADDR_W'(ZERO_REG)) && reg_write1 && (write_reg1 == read_reg2)) begin
         read_data2 = write_data1;
      end else begin
         read_data2 = rf_data2;
      end
   end
`endif

endmodule
